// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter and sequencer that shares one uart_tx serializer among
// NREQ byte requesters. A winning byte is latched and presented on uart_data.
// uart_start is held until the serializer reports busy. The block then waits
// for busy to clear before it arbitrates again.
//
// Optional build macro: UART_ARB_LOCK_EN
//   When this macro is defined, the input req_lock is added. A capture with
//   req_lock[winner]=1 locks the arbiter to that requester so that a
//   multi-byte message goes out contiguously.
//
// Ports:
//   clk_25mhz    in   1       system clock
//   reset        in   1       synchronous, active-high reset
//   req          in   NREQ    per-requester byte valid, held until req_ack
//   req_data     in   8*NREQ  byte of requester i on [8i+7:8i]
//   req_lock     in   NREQ    (UART_ARB_LOCK_EN only) keep grant after capture
//   req_ack      out  NREQ    one-cycle pulse: requester's byte captured
//   grant_id     out  IDW     index of requester owning the UART
//   active       out  1       high whenever not IDLE
//   uart_data    out  8       byte to uart_tx, stable START entry..IDLE
//   uart_start   out  1       to uart_tx start_tx
//   uart_busy    in   1       from uart_tx busy
//   err_timeout  out  1       one-cycle pulse: busy never rose within TIMEOUT
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int              NREQ    = 4,
  parameter int              IDW     = 2,
  parameter int              TW      = 16,
  parameter logic [TW-1:0]   TIMEOUT = 16'd1023
) (
  input  logic                clk_25mhz,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NREQ-1:0]     req_lock,
`endif
  output logic [NREQ-1:0]     req_ack,
  output logic [IDW-1:0]      grant_id,
  output logic                active,
  output logic [7:0]          uart_data,
  output logic                uart_start,
  input  logic                uart_busy,
  output logic                err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [NREQ-1:0] REQ_ONE = NREQ'(1);

  state_t          state_reg;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [TW-1:0]   tmo_cnt_reg;
  logic [TW-1:0]   tmo_cnt_next;
  logic [NREQ-1:0] req_eff;
  logic [IDW-1:0]  win_id;
  logic            win_found;
  logic [IDW-1:0]  rr_ptr_next;
  logic [7:0]      req_byte [NREQ];

`ifdef UART_ARB_LOCK_EN
  logic            lock_reg;
`endif

  // Unpack the flat byte bus so the winner's byte is a plain array lookup.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // First set bit of r at or above p, wrapping past NREQ-1 to 0. The loop
  // runs from the farthest offset to the nearest so the nearest hit is the
  // last assignment and wins. The MSB of the result flags "found".
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                           input logic [IDW-1:0]  p);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(p) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (r[idx[IDW-1:0]]) res = {1'b1, idx[IDW-1:0]};
    end
    return res;
  endfunction

  // While locked, only the current owner may be considered.
  always_comb begin
    req_eff = req;
`ifdef UART_ARB_LOCK_EN
    if (lock_reg) req_eff = req & (REQ_ONE << grant_id);
`endif
  end

  assign {win_found, win_id} = rr_pick(req_eff, rr_ptr_reg);
  assign rr_ptr_next  = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
  assign tmo_cnt_next = (tmo_cnt_reg == '1) ? tmo_cnt_reg : tmo_cnt_reg + 1'b1;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      rr_ptr_reg  <= '0;
      tmo_cnt_reg <= '0;
      req_ack     <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      uart_data   <= 8'h00;
      uart_start  <= 1'b0;
      err_timeout <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_reg    <= 1'b0;
`endif
    end else begin
      // Both pulses are single-cycle by default.
      req_ack     <= '0;
      err_timeout <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (win_found) begin
            uart_data   <= req_byte[win_id];
            grant_id    <= win_id;
            req_ack     <= REQ_ONE << win_id;
            tmo_cnt_reg <= '0;
            uart_start  <= 1'b1;
            active      <= 1'b1;
            state_reg   <= ST_START;
`ifdef UART_ARB_LOCK_EN
            // A locked capture keeps the pointer so the owner is re-granted.
            if (req_lock[win_id]) begin
              lock_reg   <= 1'b1;
            end else begin
              lock_reg   <= 1'b0;
              rr_ptr_reg <= rr_ptr_next;
            end
`else
            rr_ptr_reg  <= rr_ptr_next;
`endif
          end
        end

        ST_START: begin
          if (uart_busy) begin
            uart_start <= 1'b0;
            state_reg  <= ST_WAIT;
          end else begin
            tmo_cnt_reg <= tmo_cnt_next;
            // The serializer never picked the byte up. Drop it; the pointer
            // keeps its advanced value.
            if (tmo_cnt_next >= TIMEOUT) begin
              uart_start  <= 1'b0;
              err_timeout <= 1'b1;
              active      <= 1'b0;
              state_reg   <= ST_IDLE;
`ifdef UART_ARB_LOCK_EN
              lock_reg    <= 1'b0;
`endif
            end
          end
        end

        ST_WAIT: begin
          if (!uart_busy) begin
            active    <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          uart_start <= 1'b0;
          active     <= 1'b0;
          state_reg  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. It includes a small uart_tx busy model.
// The stimulus pushes the expected grants and timeout pulses. A monitor
// running on the falling edge pops and compares them as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int          NREQ     = 4;
  localparam int          IDW      = 2;
  localparam int          TW       = 16;
  localparam logic [15:0] TMO      = 16'd8;
  localparam int          BUSY_DLY = 5;   // serializer raises busy 5 edges after it sees start
  localparam int          BUSY_LEN = 20;  // and holds busy for 20 cycles
  // uart_start is visible from the grant edge through the edge that samples
  // busy=1. That is BUSY_DLY+1 samples.
  localparam int          EXP_START_LEN = 6;
  localparam int          WAIT_BOUND    = 2000;

  logic               clk_25mhz;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [8*NREQ-1:0]  req_data;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ-1:0]    req_ack;
  logic [IDW-1:0]     grant_id;
  logic               active;
  logic [7:0]         uart_data;
  logic               uart_start;
  logic               uart_busy;
  logic               err_timeout;
  logic               model_en;

  uart_tx_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .TW(TW), .TIMEOUT(TMO)
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .req_ack    (req_ack),
    .grant_id   (grant_id),
    .active     (active),
    .uart_data  (uart_data),
    .uart_start (uart_start),
    .uart_busy  (uart_busy),
    .err_timeout(err_timeout)
  );

  initial clk_25mhz = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } grant_t;

  grant_t exp_q[$];
  int compared     = 0;
  int mismatched   = 0;
  int ack_cnt      = 0;
  int err_cnt      = 0;
  int err_pending  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // uart_tx busy model
  initial begin
    uart_busy = 1'b0;
    forever begin
      @(posedge clk_25mhz);
      #1;
      if (model_en && uart_start && !reset) begin
        repeat (BUSY_DLY) @(posedge clk_25mhz);
        #1 uart_busy = 1'b1;
        repeat (BUSY_LEN) @(posedge clk_25mhz);
        #1 uart_busy = 1'b0;
      end
    end
  end

  // monitor and scoreboard
  logic prev_start  = 1'b0;
  logic prev_active = 1'b0;
  int   start_run   = 0;
  int   busy_low    = 0;

  always @(negedge clk_25mhz) begin
    if (reset) begin
      prev_start  = 1'b0;
      prev_active = 1'b0;
      start_run   = 0;
      busy_low    = 0;
    end else begin
      check("ack_onehot0", 32'($onehot0(req_ack)), 32'd1);
      if (req_ack != '0) begin
        grant_t g;
        ack_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(req_ack), 32'd0);
        end else begin
          g = exp_q.pop_front();
          $display("grant: id=%0d data=%02h ack=%b (expected id=%0d data=%02h)",
                   grant_id, uart_data, req_ack, g.id, g.data);
          check("req_ack",    32'(req_ack),    32'(4'b0001 << g.id));
          check("grant_id",   32'(grant_id),   32'(g.id));
          check("uart_data",  32'(uart_data),  32'(g.data));
          check("start_with_ack", 32'(uart_start), 32'd1);
        end
      end
      if (uart_start) start_run = (req_ack != '0) ? 1 : start_run + 1;
      if (err_timeout) begin
        err_cnt++;
        $display("timeout pulse: start_run=%0d", start_run);
        check("err_expected", 32'(err_pending > 0), 32'd1);
        if (err_pending > 0) err_pending--;
        check("start_len_timeout", 32'(start_run), 32'(TMO));
        check("start_drop_timeout", 32'(uart_start), 32'd0);
      end else if (prev_start && !uart_start) begin
        check("start_len_busy", 32'(start_run), 32'(EXP_START_LEN));
        check("busy_at_start_drop", 32'(uart_busy), 32'd1);
      end
      if (prev_active && !active && !err_timeout)
        check("idle_one_after_busy_fall", 32'(busy_low), 32'd1);
      busy_low    = uart_busy ? 0 : busy_low + 1;
      prev_start  = uart_start;
      prev_active = active;
    end
  end

  // stimulus helpers
  task automatic tick();
    @(posedge clk_25mhz);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_acks(input int n);
    int target;
    int cyc;
    target = ack_cnt + n;
    cyc    = 0;
    while (ack_cnt < target && cyc < WAIT_BOUND) begin
      tick();
      cyc++;
    end
    check("ack_wait_bound", 32'(ack_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((active || uart_busy) && cyc < WAIT_BOUND) begin
      tick();
      cyc++;
    end
    check("idle_wait_bound", 32'(!active && !uart_busy), 32'd1);
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] data);
    grant_t g;
    g.id   = id;
    g.data = data;
    exp_q.push_back(g);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ack"},     32'(req_ack),     32'd0);
    check({tag, "_grant_id"},    32'(grant_id),    32'd0);
    check({tag, "_active"},      32'(active),      32'd0);
    check({tag, "_uart_data"},   32'(uart_data),   32'd0);
    check({tag, "_uart_start"},  32'(uart_start),  32'd0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    int cyc;
    int target;
    reset    = 1'b1;
    req      = '0;
    req_lock = '0;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    model_en = 1'b1;

    // 1: reset state, then a single request
    do_reset();
    check_reset_outputs("rst");
    req_data[7:0] = 8'h41;
    push(2'd0, 8'h41);
    req = 4'b0001;
    wait_acks(1);
    req = 4'b0000;
    wait_idle();

    // 2: fairness with all four requesting
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    push(2'd0, 8'h10); push(2'd1, 8'h11); push(2'd2, 8'h12);
    push(2'd3, 8'h13); push(2'd0, 8'h10);
    req = 4'b1111;
    wait_acks(5);
    req = 4'b0000;
    wait_idle();

    // 3: wrap after a grant to 3
    do_reset();
    push(2'd3, 8'h13); push(2'd0, 8'h10); push(2'd2, 8'h12);
    req = 4'b1000;
    wait_acks(1);
    req = 4'b0101;
    wait_acks(2);
    req = 4'b0000;
    wait_idle();

    // 4: timeout with busy never rising, next requester still served
    do_reset();
    model_en = 1'b0;
    req_data = {8'h13, 8'h12, 8'hA1, 8'hA0};
    push(2'd0, 8'hA0); push(2'd1, 8'hA1);
    err_pending += 2;
    target = err_cnt + 2;
    req = 4'b0011;
    wait_acks(2);
    req = 4'b0000;
    cyc = 0;
    while (err_cnt < target && cyc < WAIT_BOUND) begin
      tick();
      cyc++;
    end
    check("timeout_wait_bound", 32'(err_cnt >= target), 32'd1);
    wait_idle();
    model_en = 1'b1;

    // 5: reset while waiting on busy clears outputs and the pointer
    do_reset();
    req_data = {8'h13, 8'h12, 8'h51, 8'h10};
    push(2'd1, 8'h51);
    req = 4'b0010;
    wait_acks(1);
    req = 4'b0000;
    cyc = 0;
    while (!(active && !uart_start && uart_busy) && cyc < WAIT_BOUND) begin
      tick();
      cyc++;
    end
    check("reach_wait_bound", 32'(active && !uart_start && uart_busy), 32'd1);
    reset = 1'b1;
    tick();
    check_reset_outputs("midrst");
    reset = 1'b0;
    cyc = 0;
    while (uart_busy && cyc < WAIT_BOUND) begin
      tick();
      cyc++;
    end
    tick();
    // The pointer is back at 0, so 1 wins over 2. A stale pointer of 2 would pick 2.
    push(2'd1, 8'h51);
    req = 4'b0110;
    wait_acks(1);
    req = 4'b0000;
    wait_idle();

`ifdef UART_ARB_LOCK_EN
    // 6: lock keeps requester 1 for a multi-byte message
    do_reset();
    req_data = {8'h13, 8'h12, 8'hC1, 8'hC0};
    push(2'd0, 8'hC0);
    push(2'd1, 8'hC1); push(2'd1, 8'hC1); push(2'd1, 8'hC1); push(2'd1, 8'hC1);
    push(2'd0, 8'hC0);
    req_lock = 4'b0010;
    req      = 4'b0011;
    wait_acks(4);
    req_lock = 4'b0000;
    wait_acks(2);
    req = 4'b0000;
    wait_idle();
`endif

    repeat (4) tick();
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("err_pending_drained", 32'(err_pending), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
